// File: rtl/store_buffer_lsu_if.sv
// Pipeline/memory bus for the store-buffer LSU: store and load request
// channels, load response channel, data-memory ports and occupancy.
interface store_buffer_lsu_if #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             st_valid;
   logic             st_ready;
   logic [14:0]      st_addr;
   logic [15:0]      st_data;
   logic             drain_en;
   logic             ld_valid;
   logic             ld_ready;
   logic [14:0]      ld_addr;
   logic [TAG_W-1:0] ld_tag;
   logic             ld_resp_valid;
   logic             ld_resp_ready;
   logic [15:0]      ld_resp_data;
   logic [TAG_W-1:0] ld_resp_tag;
   logic [14:0]      mem_raddr;
   logic [15:0]      mem_rdata;
   logic             mem_wen;
   logic [14:0]      mem_waddr;
   logic [15:0]      mem_wdata;
   logic [CNT_W-1:0] sb_count;

   modport master (
      output st_valid, st_addr, st_data, drain_en,
      output ld_valid, ld_addr, ld_tag, ld_resp_ready, mem_rdata,
      input  st_ready, ld_ready, ld_resp_valid, ld_resp_data, ld_resp_tag,
      input  mem_raddr, mem_wen, mem_waddr, mem_wdata, sb_count
   );

   modport slave (
      input  st_valid, st_addr, st_data, drain_en,
      input  ld_valid, ld_addr, ld_tag, ld_resp_ready, mem_rdata,
      output st_ready, ld_ready, ld_resp_valid, ld_resp_data, ld_resp_tag,
      output mem_raddr, mem_wen, mem_waddr, mem_wdata, sb_count
   );
endinterface

// File: rtl/store_buffer_lsu.sv
// Store buffer plus single-outstanding load unit in front of the data memory.
// Define STB_FORWARD_EN to forward load data from buffered stores.
module store_buffer_lsu #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input logic clk,
   input logic rst,
   store_buffer_lsu_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

   state_t             state_reg;
   logic [PTR_W:0]     head_reg;
   logic [PTR_W:0]     tail_reg;
   logic [PTR_W:0]     count;
   logic [14:0]        addr_arr [DEPTH];
   logic [15:0]        data_arr [DEPTH];
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               ld_acc;
   logic               fwd_reg;
   logic [15:0]        fwd_data_reg;
   logic [15:0]        hold_data_reg;
   logic [TAG_W-1:0]   tag_reg;
   logic [14:0]        raddr_reg;
   logic [15:0]        resp_data;
   logic               hit_next;
   logic [15:0]        hit_data_next;

   assign count = tail_reg - head_reg;
   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign push  = bus.st_valid && bus.st_ready;
   assign pop   = !empty && bus.drain_en;

   assign bus.st_ready  = !rst && !full;
   assign bus.mem_wen   = !rst && pop;
   assign bus.mem_waddr = addr_arr[head_reg[PTR_W-1:0]];
   assign bus.mem_wdata = data_arr[head_reg[PTR_W-1:0]];
   assign bus.sb_count  = count;

`ifdef STB_FORWARD_EN
   assign bus.ld_ready = !rst && (state_reg == IDLE);
`else
   assign bus.ld_ready = !rst && (state_reg == IDLE) && empty && !push;
`endif

   assign ld_acc        = bus.ld_valid && bus.ld_ready;
   assign bus.mem_raddr = ld_acc ? bus.ld_addr : raddr_reg;

   assign resp_data         = (state_reg == RESP) ? (fwd_reg ? fwd_data_reg : bus.mem_rdata)
                                                  : hold_data_reg;
   assign bus.ld_resp_valid = !rst && (state_reg != IDLE);
   assign bus.ld_resp_data  = resp_data;
   assign bus.ld_resp_tag   = tag_reg;

`ifdef STB_FORWARD_EN
   logic [DEPTH-1:0] valid_reg;
   logic [DEPTH-1:0] match;
   logic [PTR_W-1:0] idx;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (addr_arr[gi] == bus.ld_addr);
   end

   // Walk oldest to youngest so the youngest match overrides; a store
   // arriving in the same cycle is younger than anything buffered.
   always_comb begin
      hit_next      = 1'b0;
      hit_data_next = '0;
      idx           = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_reg[PTR_W-1:0] + PTR_W'(k);
         if (match[idx]) begin
            hit_next      = 1'b1;
            hit_data_next = data_arr[idx];
         end
      end
      if (push && (bus.st_addr == bus.ld_addr)) begin
         hit_next      = 1'b1;
         hit_data_next = bus.st_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= '0;
      end else begin
         if (push) valid_reg[tail_reg[PTR_W-1:0]] <= 1'b1;
         if (pop)  valid_reg[head_reg[PTR_W-1:0]] <= 1'b0;
      end
   end
`else
   assign hit_next      = 1'b0;
   assign hit_data_next = '0;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         addr_arr[tail_reg[PTR_W-1:0]] <= bus.st_addr;
         data_arr[tail_reg[PTR_W-1:0]] <= bus.st_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg      <= '0;
         tail_reg      <= '0;
         state_reg     <= IDLE;
         fwd_reg       <= 1'b0;
         fwd_data_reg  <= '0;
         hold_data_reg <= '0;
         tag_reg       <= '0;
         raddr_reg     <= '0;
      end else begin
         if (push) tail_reg <= tail_reg + 1'b1;
         if (pop)  head_reg <= head_reg + 1'b1;
         case (state_reg)
            IDLE: begin
               if (ld_acc) begin
                  state_reg    <= RESP;
                  fwd_reg      <= hit_next;
                  fwd_data_reg <= hit_data_next;
                  tag_reg      <= bus.ld_tag;
                  raddr_reg    <= bus.ld_addr;
               end
            end
            RESP: begin
               // Capture now so later drains cannot change a stalled response.
               hold_data_reg <= resp_data;
               state_reg     <= bus.ld_resp_ready ? IDLE : HOLD;
            end
            HOLD: begin
               if (bus.ld_resp_ready) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_store_buffer_lsu.sv
// Randomized and directed bench for store_buffer_lsu against a queue-based
// model of program-order store/load semantics.
module tb_store_buffer_lsu;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
`ifdef STB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic [14:0] a;
      logic [15:0] d;
   } st_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   store_buffer_lsu_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

   store_buffer_lsu #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Data memory seen by the DUT: one-cycle read latency, write at the edge.
   logic [15:0] env_mem [0:32767];
   always @(posedge clk) begin
      if (bus.mem_wen) env_mem[bus.mem_waddr] <= bus.mem_wdata;
      bus.mem_rdata <= env_mem[bus.mem_raddr];
   end

   logic [15:0]      model_mem [0:32767];
   st_t              sq[$];
   st_t              wlog[$];
   bit               pend;
   logic [15:0]      pend_data;
   logic [TAG_W-1:0] pend_tag;
   bit               last_acc;
   int               n_tests = 0;
   int               n_fail  = 0;

   function automatic logic [15:0] init_val(input logic [14:0] a);
      return {1'b0, a} ^ 16'h5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit stv, input logic [14:0] sa, input logic [15:0] sd,
                        input bit drn, input bit ldv, input logic [14:0] la,
                        input logic [TAG_W-1:0] lt, input bit rdy);
      bus.st_valid      = stv;
      bus.st_addr       = sa;
      bus.st_data       = sd;
      bus.drain_en      = drn;
      bus.ld_valid      = ldv;
      bus.ld_addr       = la;
      bus.ld_tag        = lt;
      bus.ld_resp_ready = rdy;
   endtask

   // One clock: compare at the falling edge, advance the model, return 1ns after the rising edge.
   task automatic tick();
      bit          exp_st_rdy, exp_wen, exp_ld_rdy, push, ld_acc;
      logic [15:0] v;
      @(negedge clk);
      exp_st_rdy = !rst && (sq.size() < DEPTH);
      push       = bus.st_valid && exp_st_rdy;
      exp_wen    = !rst && (sq.size() > 0) && bus.drain_en;
      exp_ld_rdy = !rst && !pend && (FWD || ((sq.size() == 0) && !push));
      ld_acc     = bus.ld_valid && exp_ld_rdy;

      chk("sb_count", 32'(bus.sb_count), 32'(sq.size()));
      chk("st_ready", 32'(bus.st_ready), 32'(exp_st_rdy));
      chk("mem_wen", 32'(bus.mem_wen), 32'(exp_wen));
      if (exp_wen && bus.mem_wen) begin
         chk("mem_waddr", 32'(bus.mem_waddr), 32'(sq[0].a));
         chk("mem_wdata", 32'(bus.mem_wdata), 32'(sq[0].d));
      end
      chk("ld_ready", 32'(bus.ld_ready), 32'(exp_ld_rdy));
      chk("ld_resp_valid", 32'(bus.ld_resp_valid), 32'(!rst && pend));
      if (!rst && pend) begin
         chk("ld_resp_data", 32'(bus.ld_resp_data), 32'(pend_data));
         chk("ld_resp_tag", 32'(bus.ld_resp_tag), 32'(pend_tag));
      end
      if (bus.mem_wen) wlog.push_back(st_t'{a: bus.mem_waddr, d: bus.mem_wdata});
      last_acc = ld_acc;

      if (rst) begin
         sq.delete();
         pend = 1'b0;
      end else begin
         if (ld_acc) begin
            v = model_mem[bus.ld_addr];
            foreach (sq[i]) if (sq[i].a == bus.ld_addr) v = sq[i].d;
            if (push && (bus.st_addr == bus.ld_addr)) v = bus.st_data;
            pend      = 1'b1;
            pend_data = v;
            pend_tag  = bus.ld_tag;
         end else if (pend && bus.ld_resp_ready) begin
            pend = 1'b0;
         end
         if (exp_wen) begin
            model_mem[sq[0].a] = sq[0].d;
            void'(sq.pop_front());
         end
         if (push) sq.push_back(st_t'{a: bus.st_addr, d: bus.st_data});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [14:0] a, input logic [TAG_W-1:0] t, input bit drn,
                          output logic [15:0] d, output logic [TAG_W-1:0] tg);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         drive(1'b0, '0, '0, drn, 1'b1, a, t, 1'b1);
         tick();
         ok = last_acc;
      end
      chk("ld_accept", 32'(ok), 32'd1);
      drive(1'b0, '0, '0, drn, 1'b0, '0, '0, 1'b1);
      chk("ld_latency", 32'(bus.ld_resp_valid), 32'd1);
      d  = bus.ld_resp_data;
      tg = bus.ld_resp_tag;
      tick();
   endtask

   initial begin
      logic [15:0]      d;
      logic [TAG_W-1:0] tg;

      for (int i = 0; i < 32768; i++) begin
         env_mem[i]   = init_val(15'(i));
         model_mem[i] = init_val(15'(i));
      end
      pend     = 1'b0;
      last_acc = 1'b0;
      rst      = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("rst_sb_count", 32'(bus.sb_count), 32'd0);
      chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
      chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
      chk("rst_resp_valid", 32'(bus.ld_resp_valid), 32'd0);

      // Two stores to the same word, then a load of it.
      drive(1'b1, 15'h0002, 16'h0032, 1'b0, 1'b0, '0, '0, 1'b1); tick();
      drive(1'b1, 15'h0002, 16'h0030, 1'b0, 1'b0, '0, '0, 1'b1); tick();
      do_load(15'h0002, 4'd3, !FWD, d, tg);
      chk("fwd_data", 32'(d), 32'h0030);
      chk("fwd_tag", 32'(tg), 32'd3);

      // Drain in order, then load the word back from memory.
      drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
      repeat (6) tick();
      wlog.delete();
      drive(1'b1, 15'h0002, 16'h0032, 1'b1, 1'b0, '0, '0, 1'b1); tick();
      drive(1'b1, 15'h0002, 16'h0030, 1'b1, 1'b0, '0, '0, 1'b1); tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
      repeat (4) tick();
      chk("drain_count", 32'(wlog.size()), 32'd2);
      if (wlog.size() >= 2) begin
         chk("drain_w0", 32'(wlog[0]), {1'b0, 15'h0002, 16'h0032});
         chk("drain_w1", 32'(wlog[1]), {1'b0, 15'h0002, 16'h0030});
      end
      do_load(15'h0002, 4'd5, 1'b1, d, tg);
      chk("mem_load_data", 32'(d), 32'h0030);
      chk("mem_load_tag", 32'(tg), 32'd5);

      // Fill to full, try one more, then drain.
      wlog.delete();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 15'(16'h0010 + k), 16'(16'h0100 + k), 1'b0, 1'b0, '0, '0, 1'b1);
         tick();
      end
      chk("full_st_ready", 32'(bus.st_ready), 32'd0);
      chk("full_count", 32'(bus.sb_count), 32'd4);
      drive(1'b1, 15'h0020, 16'hDEAD, 1'b0, 1'b0, '0, '0, 1'b1); tick();
      chk("full_reject", 32'(bus.sb_count), 32'd4);
      drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("drain_step", 32'(bus.sb_count), 32'(3 - k));
      end
      chk("full_wlog_size", 32'(wlog.size()), 32'd4);
      for (int k = 0; k < 4 && k < wlog.size(); k++)
         chk("full_order", 32'(wlog[k]), {1'b0, 15'(16'h0010 + k), 16'(16'h0100 + k)});

      // Stalled miss: response must hold while a store to the same word drains.
      drive(1'b0, '0, '0, 1'b1, 1'b1, 15'h0100, 4'd7, 1'b0); tick();
      drive(1'b1, 15'h0100, 16'hBEEF, 1'b1, 1'b0, '0, '0, 1'b0);
      chk("hold_resp_data", 32'(bus.ld_resp_data), 32'h5B5A);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
      tick();
      tick();
      chk("hold_valid", 32'(bus.ld_resp_valid), 32'd1);
      chk("hold_data", 32'(bus.ld_resp_data), 32'h5B5A);
      chk("hold_tag", 32'(bus.ld_resp_tag), 32'd7);
      drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b1); tick();
      chk("hold_release", 32'(bus.ld_resp_valid), 32'd0);

      // Reset with buffered stores and a load in flight.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 15'(16'h0030 + k), 16'(16'h0200 + k), 1'b0, 1'b0, '0, '0, 1'b1);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1, 15'h0030, 4'd9, 1'b0); tick();
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0); tick();
      rst = 1'b0;
      chk("rst2_sb_count", 32'(bus.sb_count), 32'd0);
      chk("rst2_mem_wen", 32'(bus.mem_wen), 32'd0);
      chk("rst2_resp_valid", 32'(bus.ld_resp_valid), 32'd0);
      repeat (3) tick();

      // Randomized traffic over a small address window to provoke hits.
      for (int c = 0; c < 2000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         drive($urandom_range(0, 1) == 1, 15'($urandom_range(0, 7)), 16'($urandom),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               15'($urandom_range(0, 7)), TAG_W'($urandom), $urandom_range(0, 9) < 7);
         tick();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
